axil_write_ctrl: RTL and testbench
==================================

AXIL_WRITE_CTRL -- requirements
Module: axil_write_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: AXI-Lite byte address width; minimum 16.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: AXI-Lite data width; 32 or 64.
REQ-003 SHALL have parameter NUM_B0_REGS, default 8: number of bank0 control registers; range 1..256.
REQ-004 SHALL have parameter B1_INDEX_WIDTH, default 3: slot index width; 2^B1_INDEX_WIDTH slots.
REQ-005 SHALL have parameter NUM_B1_FIELDS, default 9: number of fields per bank1 slot; range 1..16.
REQ-006 SHALL have port clk, input, 1: clock; all logic on the rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have AXI-Lite write ports S_AXI_AWADDR (ADDR_WIDTH), AWVALID/AWREADY, WDATA (DATA_WIDTH), WSTRB (DATA_WIDTH/8), WVALID/WREADY, BRESP (2), BVALID/BREADY, with standard directions.
REQ-009 SHALL have port wr_data, output, DATA_WIDTH: captured WDATA, held stable from commit until the next commit.
REQ-010 SHALL have port b0_set, output, NUM_B0_REGS: one-hot bank0 register write pulse.
REQ-011 SHALL have port b1_set, output, NUM_B1_FIELDS: one-hot bank1 field write pulse.
REQ-012 SHALL have port b1_index, output, B1_INDEX_WIDTH: target slot for b1_set.

Function
REQ-013 SHALL accept AW and W independently and in either order; at most one transaction outstanding.
REQ-014 SHALL use states IDLE, HAVE_A, HAVE_W, COMMIT and RESP.
  - IDLE: AW-only -> HAVE_A; W-only -> HAVE_W; both -> COMMIT.
  - HAVE_A on WVALID -> COMMIT.
  - HAVE_W on AWVALID -> COMMIT.
  - COMMIT -> RESP unconditionally.
  - RESP on BREADY -> IDLE.
REQ-015 SHALL drive AWREADY=1 only in IDLE/HAVE_W, WREADY=1 only in IDLE/HAVE_A, and BVALID=1 only in RESP.
REQ-016 SHALL register AWADDR and WDATA/WSTRB on their respective handshake cycles.
REQ-017 SHALL decode address fields as follows:
  - bank = addr[ADDR_WIDTH-1:ADDR_WIDTH-2]
  - bank0 (00): reg = addr[13:6]
  - bank1 (01): slot = addr[6 +: B1_INDEX_WIDTH], field = addr[5:2]
  - bits [1:0] ignored
REQ-018 SHALL assert exactly one b0_set/b1_set bit for exactly one cycle (COMMIT) when the write is mapped; latency is 1 cycle after the second of the AW/W handshakes.
REQ-019 SHALL treat a write as mapped only if all of the following hold; otherwise no set pulse is issued:
  - bank is 00 with reg < NUM_B0_REGS, or bank is 01 with field < NUM_B1_FIELDS;
  - captured WSTRB is all ones.
REQ-020 SHALL hold b1_index from the captured address during COMMIT; b1_index is don't-care otherwise.
REQ-021 SHALL keep BVALID asserted and the state in RESP while BREADY=0; new AW/W are not accepted in RESP.

Reset
REQ-022 SHALL, on reset low, immediately return to IDLE and clear state, wr_data, captured address and strobe, b0_set, b1_set, b1_index, and BVALID, all to 0.
REQ-023 SHALL complete no write and issue no pulse for a transaction interrupted by reset, and SHALL produce no B response for it.

Configuration
REQ-024 SHALL, when macro AXIL_WR_ERRRESP_EN is defined, return BRESP=2'b10 (SLVERR) for unmapped or partial-strobe writes and 2'b00 otherwise.
REQ-025 SHALL, without AXIL_WR_ERRRESP_EN, always return BRESP=2'b00; unmapped writes are silently dropped.

Verification
REQ-026 Bench SHALL check: AW 0x0000 and W 0x5 in the same cycle -> b0_set=8'h01 pulses one cycle later, wr_data=0x5, then BVALID with BRESP=00.
REQ-027 Bench SHALL check: W 0xDEAD first, AW 0x4084 three cycles later -> b1_index=2, b1_set bit1 pulses one cycle after AW, BRESP=00.
REQ-028 Bench SHALL check: AW 0x0240 (reg 9, beyond NUM_B0_REGS=8) -> no pulse; BRESP=10 with the macro, 00 without.
REQ-029 Bench SHALL check: WSTRB=4'b0011 to 0x0000 -> no pulse; BRESP=10 with the macro.
REQ-030 Bench SHALL check: BREADY held low 5 cycles -> BVALID stays 1, AWREADY=WREADY=0, then IDLE one cycle after BREADY.
REQ-031 Bench SHALL check: reset asserted in HAVE_A -> all outputs 0; a later full write completes normally with one pulse.

Source files
------------

// File: rtl/axil_write_ctrl.sv
// AXI-Lite write front end: accepts AW/W in any order, decodes the target register/field and
// issues a one-cycle set pulse. Optional macro AXIL_WR_ERRRESP_EN enables SLVERR responses.
module axil_write_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_B0_REGS    = 8,
    parameter int unsigned B1_INDEX_WIDTH = 3,
    parameter int unsigned NUM_B1_FIELDS  = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    output logic [DATA_WIDTH-1:0]     wr_data,
    output logic [NUM_B0_REGS-1:0]    b0_set,
    output logic [NUM_B1_FIELDS-1:0]  b1_set,
    output logic [B1_INDEX_WIDTH-1:0] b1_index
);

    typedef enum logic [2:0] {StIdle, StHaveA, StHaveW, StCommit, StResp} state_e;

    state_e                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH-1:0]     wr_data_q;
    logic [DATA_WIDTH/8-1:0]   wstrb_q;
    logic                      aw_hs, w_hs;
    logic                      commit;
    logic [1:0]                bank;
    logic [7:0]                reg_idx;
    logic [3:0]                field_idx;
    logic                      b0_hit, b1_hit, mapped;

    assign S_AXI_AWREADY = (state_q == StIdle) || (state_q == StHaveW);
    assign S_AXI_WREADY  = (state_q == StIdle) || (state_q == StHaveA);
    assign S_AXI_BVALID  = (state_q == StResp);

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign commit = (state_q == StCommit);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (aw_hs && w_hs) begin
                    state_d = StCommit;
                end else if (aw_hs) begin
                    state_d = StHaveA;
                end else if (w_hs) begin
                    state_d = StHaveW;
                end
            end
            StHaveA:  if (w_hs) state_d = StCommit;
            StHaveW:  if (aw_hs) state_d = StCommit;
            StCommit: state_d = StResp;
            StResp:   if (S_AXI_BREADY) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (aw_hs) begin
                addr_q <= S_AXI_AWADDR;
            end
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            // wr_data only moves on entry to COMMIT so it stays stable between commits.
            if (state_d == StCommit) begin
                wr_data_q <= w_hs ? S_AXI_WDATA : wdata_q;
            end
        end
    end

    assign bank      = addr_q[ADDR_WIDTH-1 -: 2];
    assign reg_idx   = addr_q[13:6];
    assign field_idx = addr_q[5:2];
    assign b0_hit    = (bank == 2'b00) && ({1'b0, reg_idx} < 9'(NUM_B0_REGS));
    assign b1_hit    = (bank == 2'b01) && ({1'b0, field_idx} < 5'(NUM_B1_FIELDS));
    assign mapped    = (b0_hit || b1_hit) && (&wstrb_q);

    always_comb begin
        b0_set = '0;
        b1_set = '0;
        for (int unsigned i = 0; i < NUM_B0_REGS; i++) begin
            b0_set[i] = commit && mapped && b0_hit && (reg_idx == 8'(i));
        end
        for (int unsigned j = 0; j < NUM_B1_FIELDS; j++) begin
            b1_set[j] = commit && mapped && b1_hit && (field_idx == 4'(j));
        end
    end

    assign b1_index = commit ? addr_q[6 +: B1_INDEX_WIDTH] : '0;
    assign wr_data  = wr_data_q;

`ifdef AXIL_WR_ERRRESP_EN
    assign S_AXI_BRESP = (S_AXI_BVALID && !mapped) ? 2'b10 : 2'b00;
`else
    assign S_AXI_BRESP = 2'b00;
`endif

    // Only a subset of the address bits is decoded.
    logic unused_addr;
    assign unused_addr = ^addr_q;

endmodule

// File: tb/tb_axil_write_ctrl.sv
// Randomized self-checking bench for axil_write_ctrl: transaction-level model plus directed
// literal scenarios. Honours AXIL_WR_ERRRESP_EN for expected BRESP.
module tb_axil_write_ctrl;

`ifdef AXIL_WR_ERRRESP_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [31:0] wr_data;
    logic [7:0]  b0_set;
    logic [8:0]  b1_set;
    logic [2:0]  b1_index;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    logic [15:0] ra;

    always #5 clk = ~clk;

    axil_write_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .wr_data      (wr_data),
        .b0_set       (b0_set),
        .b1_set       (b1_set),
        .b1_index     (b1_index)
    );

    // Transaction-level model: what has been collected, and where the write is in its life.
    typedef struct packed {
        bit          have_addr;
        bit          have_data;
        bit          pulse;
        bit          resp;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] wr;
    } model_t;

    model_t m = '0;

    function automatic bit addr_free(model_t s);
        return !s.have_addr && !s.pulse && !s.resp;
    endfunction

    function automatic bit data_free(model_t s);
        return !s.have_data && !s.pulse && !s.resp;
    endfunction

    function automatic model_t step(model_t s, logic av, logic [15:0] a, logic wv,
                                    logic [31:0] d, logic [3:0] st, logic br);
        model_t n = s;
        if (s.resp) begin
            if (br) n.resp = 1'b0;
        end else if (s.pulse) begin
            n.pulse = 1'b0;
            n.resp  = 1'b1;
        end else begin
            if (av && addr_free(s)) begin
                n.have_addr = 1'b1;
                n.addr      = a;
            end
            if (wv && data_free(s)) begin
                n.have_data = 1'b1;
                n.data      = d;
                n.strb      = st;
            end
            if (n.have_addr && n.have_data) begin
                n.have_addr = 1'b0;
                n.have_data = 1'b0;
                n.pulse     = 1'b1;
                n.wr        = n.data;
            end
        end
        return n;
    endfunction

    function automatic bit mapped_f(logic [15:0] a, logic [3:0] st);
        int bank = int'(a) / 16384;
        int rg   = (int'(a) / 64) % 256;
        int fld  = (int'(a) / 4) % 16;
        if (st != 4'hF) return 1'b0;
        if (bank == 0) return rg < 8;
        if (bank == 1) return fld < 9;
        return 1'b0;
    endfunction

    function automatic logic [7:0] exp_b0(model_t s);
        if (s.pulse && mapped_f(s.addr, s.strb) && int'(s.addr) / 16384 == 0)
            return 8'(1 << ((int'(s.addr) / 64) % 256));
        return 8'h00;
    endfunction

    function automatic logic [8:0] exp_b1(model_t s);
        if (s.pulse && mapped_f(s.addr, s.strb) && int'(s.addr) / 16384 == 1)
            return 9'(1 << ((int'(s.addr) / 4) % 16));
        return 9'h000;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '0;
        else        m <= step(m, awvalid, awaddr, wvalid, wdata, wstrb, bready);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && reset) begin
            chk("awready", awready, addr_free(m));
            chk("wready", wready, data_free(m));
            chk("bvalid", bvalid, m.resp);
            chk("b0_set", b0_set, exp_b0(m));
            chk("b1_set", b1_set, exp_b1(m));
            chk("wr_data", wr_data, m.wr);
            if (m.pulse) chk("b1_index", b1_index, (int'(m.addr) / 64) % 8);
            if (m.resp)
                chk("bresp", bresp, (ErrEn && !mapped_f(m.addr, m.strb)) ? 2'b10 : 2'b00);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic both(input logic [15:0] a, input logic [31:0] d, input logic [3:0] st);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = st; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    initial begin
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = 4'hF; wvalid = 1'b0; bready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bvalid", bvalid, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_b0_set", b0_set, 0);
        chk("rst_b1_set", b1_set, 0);
        chk("rst_awready", awready, 1);
        #1 reset = 1'b1;
        cmp_en = 1'b1;

        // Same-cycle AW/W to bank0 reg 0.
        both(16'h0000, 32'h5, 4'hF);
        @(negedge clk);
        chk("t1_b0_set", b0_set, 8'h01);
        chk("t1_wr_data", wr_data, 32'h5);
        tick(); @(negedge clk);
        chk("t1_bvalid", bvalid, 1);
        chk("t1_bresp", bresp, 2'b00);
        tick();

        // W first, AW three cycles later, bank1 slot 2 field 1.
        wdata = 32'hDEAD; wvalid = 1'b1;
        tick(); wvalid = 1'b0;
        tick(); tick();
        awaddr = 16'h4084; awvalid = 1'b1;
        tick(); awvalid = 1'b0;
        @(negedge clk);
        chk("t2_b1_index", b1_index, 3'd2);
        chk("t2_b1_set", b1_set, 9'h002);
        chk("t2_wr_data", wr_data, 32'hDEAD);
        tick(); @(negedge clk);
        chk("t2_bresp", bresp, 2'b00);
        tick();

        // Bank0 register beyond the implemented range.
        both(16'h0240, 32'h77, 4'hF);
        @(negedge clk);
        chk("t3_b0_set", b0_set, 8'h00);
        tick(); @(negedge clk);
        chk("t3_bresp", bresp, ErrEn ? 2'b10 : 2'b00);
        tick();

        // Partial strobe.
        both(16'h0000, 32'h99, 4'b0011);
        @(negedge clk);
        chk("t4_b0_set", b0_set, 8'h00);
        tick(); @(negedge clk);
        chk("t4_bresp", bresp, ErrEn ? 2'b10 : 2'b00);
        tick();

        // Back-pressure on B.
        bready = 1'b0;
        both(16'h0040, 32'h1234_5678, 4'hF);
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_bvalid", bvalid, 1);
            chk("t5_awready", awready, 0);
            chk("t5_wready", wready, 0);
            tick();
        end
        bready = 1'b1;
        tick(); @(negedge clk);
        chk("t5_idle_bvalid", bvalid, 0);
        chk("t5_idle_awready", awready, 1);

        // Reset while holding an address only.
        tick();
        awaddr = 16'h0080; awvalid = 1'b1;
        tick(); awvalid = 1'b0;
        @(negedge clk);
        chk("t6_have_a_awready", awready, 0);
        #1 reset = 1'b0;
        #1;
        chk("t6_rst_wr_data", wr_data, 0);
        chk("t6_rst_bvalid", bvalid, 0);
        chk("t6_rst_b0_set", b0_set, 0);
        chk("t6_rst_awready", awready, 1);
        tick();
        reset = 1'b1;
        both(16'h0080, 32'hCAFE, 4'hF);
        @(negedge clk);
        chk("t6_b0_set", b0_set, 8'h04);
        chk("t6_wr_data", wr_data, 32'hCAFE);
        tick(); @(negedge clk);
        chk("t6_after_b0_set", b0_set, 8'h00);
        chk("t6_bvalid", bvalid, 1);
        tick();

        // Random traffic, including occasional resets.
        for (int n = 0; n < 4000; n++) begin
            ra = 16'($urandom);
            if ($urandom % 4 != 0) ra[15] = 1'b0;
            if ($urandom % 2 != 0) ra[13:9] = 5'd0;
            awaddr  = ra;
            awvalid = ($urandom % 3) == 0;
            wvalid  = ($urandom % 3) == 0;
            wdata   = $urandom;
            wstrb   = ($urandom % 5 == 0) ? 4'($urandom) : 4'hF;
            bready  = ($urandom % 4) != 0;
            if ($urandom % 800 == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end else begin
                tick();
            end
        end

        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
